// File: rtl/muldiv_ctrl.sv
// Sequential signed 32x32 multiply / 32/32 divide unit.
// One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        mult_done,
    output logic        div_done,
    output logic        div_by_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_mult_q, is_mult_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_out_q, hi_out_d;
    logic [31:0] lo_out_q, lo_out_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] prod;

    // Magnitudes are unsigned, so 0x80000000 maps cleanly to 2^31
    assign mag_a = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign mag_b = op_b[31] ? (~op_b + 32'd1) : op_b;

    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : 32'd0)};
    assign div_shift = {hi_q, lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, a_q};
    assign div_diff  = div_shift[31:0] - a_q;
    assign prod      = {hi_q, lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_mult_d = is_mult_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_out_d  = hi_out_q;
        lo_out_d  = lo_out_q;
        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    is_mult_d = 1'b1;
                    a_d       = mag_a;
                    lo_d      = mag_b;
                    hi_d      = '0;
                    neg_res_d = op_a[31] ^ op_b[31];
                    neg_rem_d = op_a[31];
                    dbz_d     = 1'b0;
                end else if (div_start) begin
                    cnt_d     = '0;
                    is_mult_d = 1'b0;
                    a_d       = mag_b;
                    lo_d      = mag_a;
                    hi_d      = '0;
                    neg_res_d = op_a[31] ^ op_b[31];
                    neg_rem_d = op_a[31];
                    if (op_b == 32'd0) begin
                        state_d  = DONE;
                        dbz_d    = 1'b1;
                        hi_out_d = op_a;
                        lo_out_d = '1;
                    end else begin
                        state_d = CALC;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                if (is_mult_q) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[31:1]};
                end else if (div_ge) begin
                    hi_d = div_diff;
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = div_shift[31:0];
                    lo_d = {lo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (is_mult_q) begin
                    {hi_out_d, lo_out_d} = neg_res_q ? (64'd0 - prod) : prod;
                end else begin
                    lo_out_d = neg_res_q ? (32'd0 - lo_q) : lo_q;
                    hi_out_d = neg_rem_q ? (32'd0 - hi_q) : hi_q;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                dbz_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_mult_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_out_q  <= '0;
            lo_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_mult_q <= is_mult_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_out_q  <= hi_out_d;
            lo_out_q  <= lo_out_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign mult_done   = (state_q == DONE) &&  is_mult_q;
    assign div_done    = (state_q == DONE) && !is_mult_q;
    assign div_by_zero = (state_q == DONE) &&  dbz_q;
    assign hi_out      = hi_out_q;
    assign lo_out      = lo_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever a done pulse appears.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        mult_done;
    logic        div_done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    muldiv_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    typedef struct {
        logic        is_mult;
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && (mult_done || div_done)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done mult_done=%0b div_done=%0b expected=none (cycle %0d)",
                         mult_done, div_done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_kind", {62'd0, mult_done, div_done}, {62'd0, e.is_mult, ~e.is_mult});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                chk("hi_out", {32'd0, hi_out}, {32'd0, e.hi});
                chk("lo_out", {32'd0, lo_out}, {32'd0, e.lo});
            end
        end else if (reset === 1'b1 && div_by_zero) begin
            checks++;
            failures++;
            $display("FAIL stray_div_by_zero actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    task automatic to_cycle(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start for exactly one cycle; returns the cycle number it was high in.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic edbz,
                         input logic [31:0] eh, input logic [31:0] el,
                         output int unsigned c0);
        exp_t e;
        @(posedge clk);
        #1;
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        c0         = cyc;
        if (push) begin
            e.is_mult = m;
            e.dbz     = edbz;
            e.hi      = eh;
            e.lo      = el;
            e.cyc     = c0 + (edbz ? 1 : 34);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic run(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic edbz, input logic [31:0] eh, input logic [31:0] el);
        int unsigned c0;
        issue(m, ~m, a, b, 1'b1, edbz, eh, el, c0);
        to_cycle(c0 + (edbz ? 3 : 36));
    endtask

    initial begin
        int unsigned c0;
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;

        #3;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_dones", {62'd0, mult_done, div_done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        run(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // busy must be high exactly in cycles 1..34 of the operation
        begin
            exp_t e;
            e.is_mult = 1'b1; e.dbz = 1'b0;
            e.hi = 32'h3FFF_FFFF; e.lo = 32'h0000_0001;
            issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, e.hi, e.lo, c0);
            for (int unsigned i = 1; i <= 35; i++) begin
                @(negedge clk);
                chk($sformatf("busy_c%0d", cyc - c0), {63'd0, busy}, {63'd0, (i <= 34)});
            end
            to_cycle(c0 + 37);
        end

        run(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(1'b0, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF);
        run(1'b0, 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
        run(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'd3);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'd0);
        run(1'b1, 32'h8000_0000, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
        run(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 32'd1);

        repeat (5) @(posedge clk);
        #1;
        chk("hold_hilo", {hi_out, lo_out}, {32'd0, 32'd1});

        // Both starts together: multiply wins, later div_start pulses are ignored
        issue(1'b1, 1'b1, 32'd2, 32'd3, 1'b1, 1'b0, 32'd0, 32'd6, c0);
        to_cycle(c0 + 5);
        div_start = 1'b1;
        op_b      = 32'd0;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        to_cycle(c0 + 34);
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        @(negedge clk);
        chk("no_div_after_both_c35", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("no_div_after_both_c36", {63'd0, busy}, 64'd0);
        to_cycle(c0 + 40);

        // Reset mid-multiply aborts with no done pulse
        issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0, c0);
        to_cycle(c0 + 10);
        reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_dones", {62'd0, mult_done, div_done}, 64'd0);
        chk("abort_hilo", {hi_out, lo_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run(1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 mult_start  input  1  start a signed multiply, sampled only in IDLE.
REQ-005 div_start  input  1  start a signed divide, sampled only in IDLE.
REQ-006 op_a  input  32  multiplicand or dividend (rs), sampled with start.
REQ-007 op_b  input  32  multiplier or divisor (rt), sampled with start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 mult_done  output  1  one-cycle pulse when a multiply result is valid.
REQ-010 div_done  output  1  one-cycle pulse when a divide result is valid.
REQ-011 div_by_zero  output  1  high with div_done when the divisor was zero.
REQ-012 hi_out  output  32  product[63:32] or remainder.
REQ-013 lo_out  output  32  product[31:0] or quotient.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE, encoded in 2 bits.
REQ-015 In IDLE, mult_start=1 at a rising edge SHALL latch |op_a| and |op_b| plus the result sign, clear the 5-bit iteration counter, and enter CALC.
REQ-016 In IDLE, div_start=1 with mult_start=0 SHALL behave the same for a divide; if op_b=0, the FSM SHALL skip CALC and FIX and enter DONE directly.
REQ-017 If mult_start and div_start are both 1 in the same cycle, the multiply SHALL win and div_start SHALL be ignored.
REQ-018 mult_start and div_start SHALL be ignored in CALC, FIX and DONE; no queuing.
REQ-019 CALC SHALL last exactly 32 cycles with one iteration per cycle: unsigned shift-add for multiply, restoring shift-subtract for divide; at counter=31 the FSM SHALL go to FIX.
REQ-020 FIX SHALL last 1 cycle: it applies two's-complement negation to the product when operand signs differ, to the quotient when signs differ, and to the remainder when the dividend is negative.
REQ-021 FIX SHALL write hi_out and lo_out and go to DONE.
REQ-022 DONE SHALL last 1 cycle, assert exactly one of mult_done or div_done, and return to IDLE.
REQ-023 Latency: with start high in cycle 0, done SHALL be high in cycle 34; for divide-by-zero, div_done SHALL be high in cycle 1.
REQ-024 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-025 0x80000000 / 0xFFFFFFFF SHALL yield lo_out=0x80000000 and hi_out=0 (wrap, no trap).
REQ-026 On divide-by-zero, hi_out SHALL equal op_a, lo_out SHALL equal 0xFFFFFFFF, and div_by_zero SHALL be 1 during DONE only.
REQ-027 hi_out and lo_out SHALL be registered and change only on entry to DONE; they SHALL hold their values until the next completion, so the consumer may sample them in the done cycle or later.
REQ-028 The magnitude of 0x80000000 SHALL be handled as the unsigned value 2^31 without error.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, busy=0, mult_done=0, div_done=0, div_by_zero=0, hi_out=0, lo_out=0, and clear all internal registers.
REQ-030 reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 The first start after reset is released SHALL be accepted normally.

Verification
REQ-032 mult op_a=7, op_b=0xFFFFFFFD (-3) -> mult_done in cycle 34, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
REQ-033 mult 0x7FFFFFFF x 0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001; busy=1 in cycles 1-34.
REQ-034 div 0xFFFFFFF9 (-7) / 2 -> div_done in cycle 34, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF, div_by_zero=0.
REQ-035 div 5 / 0 -> div_done and div_by_zero high in cycle 1 only, hi_out=5, lo_out=0xFFFFFFFF.
REQ-036 mult_start and div_start together, then div_start pulses in cycles 5 and 34 -> only mult_done fires in cycle 34 and no divide starts.
REQ-037 reset=0 in cycle 10 of a multiply -> outputs 0 and no done; a new mult 3 x 4 started after release -> lo_out=12, hi_out=0 after 34 cycles.
